mouse_pos_to_cell: RTL and testbench

MOUSE_POS_TO_CELL -- requirements
Module: mouse_pos_to_cell

---
 rtl/mouse_pos_to_cell.sv | 153 +++++++++++++++
 tb/tb_mouse_pos_to_cell.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_pos_to_cell.sv
// Maps a pointer position to a grid cell by repeated subtraction, x and y in parallel.
// Optional build macro MOUSE_CELL_CHANGE_ONLY_EN: emit cell_valid only when the result changes.
module mouse_pos_to_cell #(
  parameter int COORD_W = 10,
  parameter int IDX_W   = 4,
  parameter int CELL_W  = 48,
  parameter int CELL_H  = 64,
  parameter int N_COLS  = 10,
  parameter int N_ROWS  = 10
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               pos_valid,
  output logic               pos_ready,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  output logic [IDX_W-1:0]   cell_col,
  output logic [IDX_W-1:0]   cell_row,
  output logic               out_of_range,
  output logic               cell_valid
);

  // Remainders must also be able to hold the cell size so the >= compare never truncates it.
  localparam int CXW   = $clog2(CELL_W + 1);
  localparam int CYW   = $clog2(CELL_H + 1);
  localparam int RXW   = (COORD_W > CXW) ? COORD_W : CXW;
  localparam int RYW   = (COORD_W > CYW) ? COORD_W : CYW;
  localparam int CNTXW = $clog2(N_COLS + 1);
  localparam int CNTYW = $clog2(N_ROWS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [RXW-1:0]    rem_x_q, rem_x_d;
  logic [RYW-1:0]    rem_y_q, rem_y_d;
  logic [CNTXW-1:0]  cnt_x_q, cnt_x_d;
  logic [CNTYW-1:0]  cnt_y_q, cnt_y_d;
  logic [IDX_W-1:0]  col_q, col_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic              oor_q, oor_d;
  logic              step_x, step_y;
  logic              emit;

`ifdef MOUSE_CELL_CHANGE_ONLY_EN
  logic                   have_last_q, have_last_d;
  logic [2*IDX_W:0]       last_q, last_d;
`endif

  // Counters saturate at the grid size, which is what flags out_of_range.
  assign step_x = (rem_x_q >= RXW'(CELL_W)) && (cnt_x_q < CNTXW'(N_COLS));
  assign step_y = (rem_y_q >= RYW'(CELL_H)) && (cnt_y_q < CNTYW'(N_ROWS));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    rem_x_d = rem_x_q;
    rem_y_d = rem_y_q;
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    col_d   = col_q;
    row_d   = row_q;
    oor_d   = oor_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pos_valid) begin
          rem_x_d = RXW'(pos_x);
          rem_y_d = RYW'(pos_y);
          cnt_x_d = '0;
          cnt_y_d = '0;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        if (step_x) begin
          rem_x_d = rem_x_q - RXW'(CELL_W);
          cnt_x_d = cnt_x_q + CNTXW'(1);
        end
        if (step_y) begin
          rem_y_d = rem_y_q - RYW'(CELL_H);
          cnt_y_d = cnt_y_q + CNTYW'(1);
        end
        if (!step_x && !step_y) begin
          oor_d   = (cnt_x_q == CNTXW'(N_COLS)) || (cnt_y_q == CNTYW'(N_ROWS));
          col_d   = (cnt_x_q == CNTXW'(N_COLS)) ? IDX_W'(N_COLS - 1) : IDX_W'(cnt_x_q);
          row_d   = (cnt_y_q == CNTYW'(N_ROWS)) ? IDX_W'(N_ROWS - 1) : IDX_W'(cnt_y_q);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MOUSE_CELL_CHANGE_ONLY_EN
  always_comb begin
    have_last_d = have_last_q;
    last_d      = last_q;
    emit        = (state_q == ST_DONE) &&
                  (!have_last_q || ({col_q, row_q, oor_q} != last_q));
    if (emit) begin
      have_last_d = 1'b1;
      last_d      = {col_q, row_q, oor_q};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      have_last_q <= 1'b0;
      last_q      <= '0;
    end else begin
      have_last_q <= have_last_d;
      last_q      <= last_d;
    end
  end
`else
  assign emit = (state_q == ST_DONE);
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      rem_x_q <= '0;
      rem_y_q <= '0;
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      oor_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q <= state_d;
      rem_x_q <= rem_x_d;
      rem_y_q <= rem_y_d;
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
      col_q   <= col_d;
      row_q   <= row_d;
      oor_q   <= oor_d;
    end
  end

  assign pos_ready    = (state_q == ST_IDLE);
  assign cell_valid   = emit;
  assign cell_col     = col_q;
  assign cell_row     = row_q;
  assign out_of_range = oor_q;

endmodule

// File: tb/tb_mouse_pos_to_cell.sv
// Scoreboard bench for mouse_pos_to_cell: expectations queued at acceptance, checked on cell_valid.
module tb_mouse_pos_to_cell;

  localparam int COORD_W = 10;
  localparam int IDX_W   = 4;
  localparam int CELL_W  = 48;
  localparam int CELL_H  = 64;
  localparam int N_COLS  = 10;
  localparam int N_ROWS  = 10;

  typedef struct {
    int col;
    int row;
    int oor;
    int lat;
    int acc_cyc;
  } exp_t;

  logic               clk_in = 1'b0;
  logic               rst_n_in = 1'b0;
  logic               pos_valid = 1'b0;
  logic               pos_ready;
  logic [COORD_W-1:0] pos_x = '0;
  logic [COORD_W-1:0] pos_y = '0;
  logic [IDX_W-1:0]   cell_col;
  logic [IDX_W-1:0]   cell_row;
  logic               out_of_range;
  logic               cell_valid;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  exp_t sb[$];

  int   have_last = 0;
  int   last_col = 0, last_row = 0, last_oor = 0;

  mouse_pos_to_cell #(
    .COORD_W(COORD_W), .IDX_W(IDX_W), .CELL_W(CELL_W), .CELL_H(CELL_H),
    .N_COLS(N_COLS), .N_ROWS(N_ROWS)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .pos_valid(pos_valid), .pos_ready(pos_ready),
    .pos_x(pos_x), .pos_y(pos_y),
    .cell_col(cell_col), .cell_row(cell_row),
    .out_of_range(out_of_range), .cell_valid(cell_valid)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Reference: plain division, clamped to the grid; busy cycles = Q+1 DIV plus one DONE.
  task automatic accept(input int x, input int y, output int q);
    int   cr, rr, budget;
    exp_t e;
    budget = 0;
    while (!pos_ready && budget < 100) begin
      @(negedge clk_in);
      budget++;
    end
    checks++;
    if (!pos_ready) begin
      errors++;
      $display("FAIL accept_wait: pos_ready=%0b required 1 for (%0d,%0d)", pos_ready, x, y);
    end
    @(negedge clk_in);
    pos_valid = 1'b1;
    pos_x = COORD_W'(x);
    pos_y = COORD_W'(y);
    @(posedge clk_in);
    #1;
    pos_valid = 1'b0;
    cr = x / CELL_W;
    rr = y / CELL_H;
    if (cr > N_COLS) cr = N_COLS;
    if (rr > N_ROWS) rr = N_ROWS;
    q = (cr > rr) ? cr : rr;
    e.oor = (cr == N_COLS || rr == N_ROWS) ? 1 : 0;
    e.col = (cr == N_COLS) ? N_COLS - 1 : cr;
    e.row = (rr == N_ROWS) ? N_ROWS - 1 : rr;
    e.lat = q + 1;
    e.acc_cyc = cyc;
`ifdef MOUSE_CELL_CHANGE_ONLY_EN
    if (!(have_last != 0 && e.col == last_col && e.row == last_row && e.oor == last_oor))
      sb.push_back(e);
`else
    sb.push_back(e);
`endif
    have_last = 1;
    last_col = e.col;
    last_row = e.row;
    last_oor = e.oor;
  endtask

  task automatic send(input int x, input int y);
    int q, busy;
    accept(x, y, q);
    busy = 0;
    @(negedge clk_in);
    while (!pos_ready && busy < 100) begin
      busy++;
      @(negedge clk_in);
    end
    checks++;
    if (busy != q + 2) begin
      errors++;
      $display("FAIL busy_cycles(%0d,%0d): got %0d required %0d", x, y, busy, q + 2);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      @(negedge clk_in);
      budget++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never produced", sb.size());
      sb.delete();
    end
    checks++;
    if (cell_col !== IDX_W'(last_col) || cell_row !== IDX_W'(last_row) ||
        out_of_range !== last_oor[0]) begin
      errors++;
      $display("FAIL hold: got col=%0d row=%0d oor=%0b required col=%0d row=%0d oor=%0d",
               cell_col, cell_row, out_of_range, last_col, last_row, last_oor);
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++;
    if (cell_col !== '0 || cell_row !== '0 || out_of_range !== 1'b0 || cell_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: col=%0d row=%0d oor=%0b valid=%0b required all 0",
               cell_col, cell_row, out_of_range, cell_valid);
    end
    rst_n_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (pos_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: pos_ready=%0b required 1", pos_ready);
    end
  endtask

  task automatic test_origin();
    send(0, 0);
    drain();
  endtask

  task automatic test_boundary();
    send(47, 63);
    drain();
    send(48, 64);
    drain();
  endtask

  task automatic test_grid_corner();
    send(479, 639);
    drain();
  endtask

  task automatic test_out_of_range();
    send(480, 100);
    drain();
    send(1023, 1023);
    drain();
  endtask

  task automatic test_reset_mid_div();
    int q;
    accept(479, 639, q);
    repeat (3) @(posedge clk_in);
    #1;
    rst_n_in = 1'b0;
    sb.delete();
    have_last = 0;
    last_col = 0;
    last_row = 0;
    last_oor = 0;
    #1;
    checks++;
    if (cell_col !== '0 || cell_row !== '0 || out_of_range !== 1'b0 || cell_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_div_reset: col=%0d row=%0d oor=%0b valid=%0b required all 0",
               cell_col, cell_row, out_of_range, cell_valid);
    end
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    pulses = 0;
    repeat (20) @(negedge clk_in);
    checks++;
    if (pulses != 0 || pos_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_div_after: pulses=%0d pos_ready=%0b required 0 and 1", pulses, pos_ready);
    end
  endtask

  task automatic test_back_to_back();
    int expect_pulses;
`ifdef MOUSE_CELL_CHANGE_ONLY_EN
    expect_pulses = 1;
`else
    expect_pulses = 2;
`endif
    pulses = 0;
    send(100, 100);
    send(100, 100);
    drain();
    checks++;
    if (pulses != expect_pulses) begin
      errors++;
      $display("FAIL back_to_back_pulses: got %0d required %0d", pulses, expect_pulses);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk_in);
        if (rst_n_in && cell_valid) begin
          exp_t e;
          pulses++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: cell_valid=1 with col=%0d row=%0d required no pulse",
                     cell_col, cell_row);
          end else begin
            e = sb.pop_front();
            if (cell_col !== IDX_W'(e.col) || cell_row !== IDX_W'(e.row) ||
                out_of_range !== e.oor[0] || (cyc - e.acc_cyc) != e.lat) begin
              errors++;
              $display("FAIL result: got col=%0d row=%0d oor=%0b lat=%0d required col=%0d row=%0d oor=%0d lat=%0d",
                       cell_col, cell_row, out_of_range, cyc - e.acc_cyc,
                       e.col, e.row, e.oor, e.lat);
            end
          end
        end
      end
    join_none

    test_reset();
    test_origin();
    test_boundary();
    test_grid_corner();
    test_out_of_range();
    test_reset_mid_div();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
